serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor, the sequential successor to the team's gate-level half/full adder and subtractor cells.
- Takes two WIDTH-bit operands, an add/sub mode and a carry/borrow-in.
- Processes one bit per clock through a single combined full-adder/full-subtractor cell, LSB first.
- Presents a registered result with carry/borrow-out and a one-cycle done pulse.
- Used where area matters more than latency, e.g. shared arithmetic in lab datapaths.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_cell.sv | 21 ++
 rtl/serial_addsub.sv | 103 ++++++++++
 tb/tb_serial_addsub.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_cell.sv
// Combinational 1-bit full adder / full subtractor; cOut is carry (add) or borrow (sub).
module addsub_cell
   import serial_addsub_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic cIn,
   input  logic mode,
   output logic s,
   output logic cOut
);

   always_comb begin
      s = x ^ y ^ cIn;
      if (mode == MODE_SUB)
         cOut = (~x & y) | (~(x ^ y) & cIn);
      else
         cOut = (x & y) | ((x ^ y) & cIn);
   end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock through a single cell.
// Optional signed-overflow output enabled by SERIAL_ADDSUB_OVF_EN.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cBin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cOut
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic             c;
   logic             mode_q;
   logic [CW-1:0]    cnt;
   logic             sum_bit;
   logic             c_nxt;
   logic             last;

   addsub_cell u_cell (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .cIn  (c),
      .mode (mode_q),
      .s    (sum_bit),
      .cOut (c_nxt)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         r_sh   <= '0;
         c      <= 1'b0;
         mode_q <= MODE_ADD;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cOut   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  mode_q <= mode;
                  c      <= cBin;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sh <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh <= {1'b0, b_sh[WIDTH-1:1]};
               r_sh <= {sum_bit, r_sh[WIDTH-1:1]};
               c    <= c_nxt;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  // the MSB bit is folded in here; r_sh itself lags by one edge
                  result <= {sum_bit, r_sh[WIDTH-1:1]};
                  cOut   <= c_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
                  ovf    <= c ^ c_nxt;
`endif
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed + scoreboard bench for serial_addsub (WIDTH=8 and WIDTH=2 instances).
module tb_serial_addsub;
   import serial_addsub_pkg::*;

   typedef struct {
      logic [63:0] res;
      logic        co;
      logic        ov;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       start8 = 0, mode8 = 0, cbin8 = 0;
   logic [7:0] a8 = 0, b8 = 0;
   logic       busy8, done8, cout8;
   logic [7:0] res8;

   logic       start2 = 0, mode2 = 0, cbin2 = 0;
   logic [1:0] a2 = 0, b2 = 0;
   logic       busy2, done2, cout2;
   logic [1:0] res2;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic       ovf8, ovf2;
`endif

   int nvec = 0;
   int nerr = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
      .cBin(cbin8), .busy(busy8), .done(done8), .result(res8), .cOut(cout8)
`ifdef SERIAL_ADDSUB_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_addsub #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a(a2), .b(b2),
      .cBin(cbin2), .busy(busy2), .done(done2), .result(res2), .cOut(cout2)
`ifdef SERIAL_ADDSUB_OVF_EN
      , .ovf(ovf2)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: independent wide arithmetic plus sign-based overflow.
   function automatic exp_t model(input int w, input logic md, input logic [63:0] a,
                                  input logic [63:0] b, input logic ci);
      exp_t e;
      logic [64:0] full;
      logic [63:0] mask;
      logic sa, sb_, sr;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      if (md == MODE_ADD) full = {1'b0, a} + {1'b0, b} + 65'(ci);
      else                full = {1'b0, a} - {1'b0, b} - 65'(ci);
      e.res = full[63:0] & mask;
      e.co  = full[w];
      sa = a[w-1]; sb_ = b[w-1]; sr = e.res[w-1];
      if (md == MODE_ADD) e.ov = (sa == sb_) && (sr != sa);
      else                e.ov = (sa != sb_) && (sr != sa);
      return e;
   endfunction

   task automatic check_out8(input string tag, input int lat);
      exp_t e;
      e = sb.pop_front();
      chk({tag, ".lat"}, 64'(lat), 64'd9);
      chk({tag, ".res"}, 64'(res8), e.res);
      chk({tag, ".cout"}, 64'(cout8), 64'(e.co));
`ifdef SERIAL_ADDSUB_OVF_EN
      chk({tag, ".ovf"}, 64'(ovf8), 64'(e.ov));
`endif
   endtask

   // One WIDTH=8 operation: drive, push expectation, wait (bounded) for done.
   task automatic op8(input string tag, input logic md, input logic [7:0] a,
                      input logic [7:0] b, input logic ci);
      int k, nbusy;
      @(negedge clk);
      start8 = 1; mode8 = md; a8 = a; b8 = b; cbin8 = ci;
      sb.push_back(model(8, md, 64'(a), 64'(b), ci));
      nbusy = 0;
      k = 0;
      do begin
         @(negedge clk);
         start8 = 0; a8 = ~a; b8 = ~b; cbin8 = ~ci;
         k++;
         if (busy8) nbusy++;
      end while (!done8 && k < 20);
      if (!done8) begin
         chk({tag, ".timeout"}, 64'd0, 64'd1);
         void'(sb.pop_front());
      end else begin
         check_out8(tag, k);
         chk({tag, ".busycyc"}, 64'(nbusy), 64'd8);
         chk({tag, ".busy_in_done"}, 64'(busy8), 64'd0);
      end
   endtask

   task automatic op2(input logic md, input logic [1:0] a, input logic [1:0] b,
                      input logic ci);
      int k;
      exp_t e;
      @(negedge clk);
      start2 = 1; mode2 = md; a2 = a; b2 = b; cbin2 = ci;
      sb.push_back(model(2, md, 64'(a), 64'(b), ci));
      k = 0;
      do begin
         @(negedge clk);
         start2 = 0;
         k++;
      end while (!done2 && k < 10);
      e = sb.pop_front();
      if (!done2) chk("w2.timeout", 64'd0, 64'd1);
      else begin
         chk("w2.lat", 64'(k), 64'd3);
         chk("w2.res", 64'(res2), e.res);
         chk("w2.cout", 64'(cout2), 64'(e.co));
`ifdef SERIAL_ADDSUB_OVF_EN
         chk("w2.ovf", 64'(ovf2), 64'(e.ov));
`endif
      end
   endtask

   initial begin : main
      int k, ndone;
      // reset state
      #12;
      chk("rst.busy", 64'(busy8), 64'd0);
      chk("rst.done", 64'(done8), 64'd0);
      chk("rst.res", 64'(res8), 64'd0);
      chk("rst.cout", 64'(cout8), 64'd0);
      @(negedge clk);
      rst = 0;

      op8("add_5a_3c", MODE_ADD, 8'h5A, 8'h3C, 1'b0);
      op8("add_ff_01", MODE_ADD, 8'hFF, 8'h01, 1'b0);
      op8("add_7f_01", MODE_ADD, 8'h7F, 8'h01, 1'b0);
      op8("add_cin",   MODE_ADD, 8'hFF, 8'hFF, 1'b1);
      op8("sub_10_20", MODE_SUB, 8'h10, 8'h20, 1'b0);
      op8("sub_80_01", MODE_SUB, 8'h80, 8'h01, 1'b0);
      op8("sub_00_00b",MODE_SUB, 8'h00, 8'h00, 1'b1);
      op8("sub_55_33", MODE_SUB, 8'h55, 8'h33, 1'b0);

      // start held high through RUN with changing operands
      @(negedge clk);
      start8 = 1; mode8 = MODE_ADD; a8 = 8'h11; b8 = 8'h22; cbin8 = 0;
      sb.push_back(model(8, MODE_ADD, 64'h11, 64'h22, 1'b0));
      ndone = 0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); cbin8 = 1'($urandom);
         if (done8) ndone++;
      end
      chk("hold.done_at_9", 64'(done8), 64'd1);
      chk("hold.ndone", 64'(ndone), 64'd1);
      check_out8("hold", 9);
      @(negedge clk);
      chk("hold.idle_busy", 64'(busy8), 64'd0);
      chk("hold.idle_done", 64'(done8), 64'd0);
      a8 = 8'h40; b8 = 8'h03; mode8 = MODE_SUB; cbin8 = 1;
      sb.push_back(model(8, MODE_SUB, 64'h40, 64'h03, 1'b1));
      @(negedge clk);
      chk("hold.reaccept", 64'(busy8), 64'd1);
      start8 = 0;
      k = 1;
      while (!done8 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!done8) begin
         chk("hold2.timeout", 64'd0, 64'd1);
         void'(sb.pop_front());
      end else check_out8("hold2", k);

      // reset during the third RUN cycle aborts with no done
      @(negedge clk);
      start8 = 1; mode8 = MODE_ADD; a8 = 8'h0F; b8 = 8'h0F; cbin8 = 0;
      repeat (3) begin
         @(negedge clk);
         start8 = 0;
      end
      rst = 1;
      #1;
      chk("abort.busy", 64'(busy8), 64'd0);
      chk("abort.done", 64'(done8), 64'd0);
      chk("abort.res", 64'(res8), 64'd0);
      chk("abort.cout", 64'(cout8), 64'd0);
      @(negedge clk);
      rst = 0;
      ndone = 0;
      repeat (10) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      chk("abort.nodone", 64'(ndone), 64'd0);
      op8("post_rst", MODE_ADD, 8'h01, 8'h01, 1'b0);

      // WIDTH=2 exhaustive
      for (int m = 0; m < 2; m++)
         for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
               for (int ci = 0; ci < 2; ci++)
                  op2(1'(m), 2'(x), 2'(y), 1'(ci));

      chk("sb.empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
